// File: rtl/ft245_sync_device.sv
// FTDI-side model of an FT245 synchronous FIFO link: presents the chip's bus and
// flags to a host master and bridges each direction to AXI-Stream through a FIFO.
module ft245_sync_device #(
   parameter int bus_width  = 1,
   parameter int fifo_depth = 16
) (
   input  logic                   ft245_dclk,
   input  logic                   rstn,
   inout  wire  [bus_width*8-1:0] ft245_data,
   inout  wire  [bus_width-1:0]   ft245_ben,
   input  logic                   ft245_rdn,
   input  logic                   ft245_wrn,
   input  logic                   ft245_oen,
   input  logic                   ft245_siwun,
   input  logic                   ft245_rstn,
   input  logic                   ft245_wakeupn,
   output logic                   ft245_rxfn,
   output logic                   ft245_txen,
   output logic [bus_width*8-1:0] m_axis_tdata,
   output logic [bus_width-1:0]   m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   input  logic [bus_width*8-1:0] s_axis_tdata,
   input  logic [bus_width-1:0]   s_axis_tkeep,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready
);
   localparam int DW = bus_width * 8;
   localparam int RW = bus_width + DW;
   localparam int TW = RW + 1;
   localparam int AW = $clog2(fifo_depth);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   localparam cnt_t FULL = cnt_t'(fifo_depth);

   logic [RW-1:0] rx_mem_q [fifo_depth];
   logic [RW-1:0] rx_mem_d [fifo_depth];
   ptr_t          rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   cnt_t          rx_cnt_q, rx_cnt_d;
   logic          rxfn_q, rxfn_d;
   logic          rx_push, rx_pop, bus_oe;
   logic [RW-1:0] rx_head;

   logic [TW-1:0] tx_mem_q [fifo_depth];
   logic [TW-1:0] tx_mem_d [fifo_depth];
   ptr_t          tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_tail;
   cnt_t          tx_cnt_q, tx_cnt_d;
   logic          txen_q, txen_d;
   logic          tx_push, tx_pop, siwu_set;

   logic          m_valid_q, m_valid_d;
   logic [DW-1:0] m_data_q, m_data_d;
   logic [bus_width-1:0] m_keep_q, m_keep_d;
   logic          m_last_q, m_last_d;

   logic          flush;
   logic          unused_wakeup;

   assign unused_wakeup = ft245_wakeupn;
   assign flush         = !ft245_rstn;

   assign s_axis_tready = rstn && (rx_cnt_q < FULL);
   assign rx_push       = s_axis_tvalid && s_axis_tready;
   assign rx_pop        = !ft245_rdn && !ft245_oen && !rxfn_q;

   // Empty FIFO drives zeros rather than a stale entry.
   assign rx_head    = (rx_cnt_q != '0) ? rx_mem_q[rx_rd_q] : '0;
   assign bus_oe     = !ft245_oen && rstn;
   assign ft245_data = bus_oe ? rx_head[DW-1:0]  : 'z;
   assign ft245_ben  = bus_oe ? rx_head[RW-1:DW] : 'z;

   assign tx_push  = !ft245_wrn && !txen_q;
   assign tx_pop   = m_valid_q && m_axis_tready;
   assign tx_tail  = tx_wr_q - ptr_t'(1);
   assign siwu_set = !ft245_siwun && !tx_push && (tx_cnt_q != '0);

   always_comb begin
      rx_mem_d = rx_mem_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      rxfn_d   = rxfn_q;
      if (flush) begin
         rx_wr_d  = '0;
         rx_rd_d  = '0;
         rx_cnt_d = '0;
         rxfn_d   = 1'b1;
      end else begin
         if (rx_push) begin
            rx_mem_d[rx_wr_q] = {s_axis_tkeep, s_axis_tdata};
            rx_wr_d = rx_wr_q + ptr_t'(1);
         end
         if (rx_pop) rx_rd_d = rx_rd_q + ptr_t'(1);
         rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
         // Falls a cycle late but rises immediately, so it never advertises an empty FIFO.
         rxfn_d = (rx_cnt_d == '0) || (rx_cnt_q == '0);
      end
   end

   always_comb begin
      tx_mem_d  = tx_mem_q;
      tx_wr_d   = tx_wr_q;
      tx_rd_d   = tx_rd_q;
      tx_cnt_d  = tx_cnt_q;
      txen_d    = txen_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
      if (flush) begin
         tx_wr_d   = '0;
         tx_rd_d   = '0;
         tx_cnt_d  = '0;
         txen_d    = 1'b0;
         m_valid_d = 1'b0;
      end else begin
         if (tx_push) begin
            tx_mem_d[tx_wr_q] = {!ft245_siwun, ft245_ben, ft245_data};
            tx_wr_d = tx_wr_q + ptr_t'(1);
         end
         if (siwu_set) tx_mem_d[tx_tail][TW-1] = 1'b1;
         if (tx_pop) tx_rd_d = tx_rd_q + ptr_t'(1);
         tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
         txen_d   = (tx_cnt_d == FULL) || (tx_cnt_q == FULL);
         // Output register tracks the post-edge head, including same-edge writes.
         m_valid_d = (tx_cnt_d != '0);
         if (m_valid_d) {m_last_d, m_keep_d, m_data_d} = tx_mem_d[tx_rd_d];
      end
   end

   always_ff @(posedge ft245_dclk) begin
      if (!rstn) begin
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         rx_cnt_q  <= '0;
         rxfn_q    <= 1'b1;
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         txen_q    <= 1'b1;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
      end else begin
         rx_wr_q   <= rx_wr_d;
         rx_rd_q   <= rx_rd_d;
         rx_cnt_q  <= rx_cnt_d;
         rxfn_q    <= rxfn_d;
         tx_wr_q   <= tx_wr_d;
         tx_rd_q   <= tx_rd_d;
         tx_cnt_q  <= tx_cnt_d;
         txen_q    <= txen_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
         m_last_q  <= m_last_d;
      end
   end

   always_ff @(posedge ft245_dclk) begin
      rx_mem_q <= rx_mem_d;
      tx_mem_q <= tx_mem_d;
   end

   assign ft245_rxfn    = rxfn_q;
   assign ft245_txen    = txen_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_ft245_sync_device.sv
// Directed bench for ft245_sync_device: vector table for reset/RX stream/send-immediate,
// plus hand-written sequences for FIFO full, backpressure and flush.
module tb_ft245_sync_device;
   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic       clk;
   logic       rstn, frstn, rdn, wrn, oen, siwun, wakeupn;
   logic [7:0] hd;
   logic       m_tready, s_tvalid;
   logic [7:0] s_tdata;
   logic [0:0] s_tkeep;
   wire  [7:0] ft245_data;
   wire  [0:0] ft245_ben;
   logic       ft245_rxfn, ft245_txen;
   logic [7:0] m_tdata;
   logic [0:0] m_tkeep;
   logic       m_tlast, m_tvalid, s_tready;

   int checks   = 0;
   int failures = 0;

   // Host drives the bus whenever it is not asking the device to drive.
   assign ft245_data = oen ? hd : 8'hzz;
   assign ft245_ben  = oen ? 1'b1 : 1'bz;

   ft245_sync_device #(.bus_width(1), .fifo_depth(16)) dut (
      .ft245_dclk(clk), .rstn(rstn), .ft245_data(ft245_data), .ft245_ben(ft245_ben),
      .ft245_rdn(rdn), .ft245_wrn(wrn), .ft245_oen(oen), .ft245_siwun(siwun),
      .ft245_rstn(frstn), .ft245_wakeupn(wakeupn), .ft245_rxfn(ft245_rxfn),
      .ft245_txen(ft245_txen), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
      .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      bit rstn; bit frstn; bit sv; logic [7:0] sd; bit oen; bit rdn; bit wrn; bit siwun;
      logic [7:0] hd; bit mr;
      bit cb; logic [7:0] eb; bit eben;
      bit erxfn; bit etxen; bit esr; bit emv;
      bit cm; logic [7:0] emd; bit eml; bit emk;
   } vec_t;

   vec_t tbl [24];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      s_tvalid = 1'b0; s_tdata = 8'h00; oen = 1'b1; rdn = 1'b1; wrn = 1'b1;
      siwun = 1'b1; hd = 8'h00; m_tready = 1'b0; frstn = 1'b1;
   endtask

   task automatic apply(input int idx, input vec_t v);
      @(negedge clk);
      rstn = v.rstn; frstn = v.frstn; s_tvalid = v.sv; s_tdata = v.sd; oen = v.oen;
      rdn = v.rdn; wrn = v.wrn; siwun = v.siwun; hd = v.hd; m_tready = v.mr;
      #1;
      if (v.cb) begin
         chk($sformatf("v%0d_bus", idx), 32'(ft245_data), 32'(v.eb));
         chk($sformatf("v%0d_ben", idx), 32'(ft245_ben), 32'(v.eben));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rxfn", idx), 32'(ft245_rxfn), 32'(v.erxfn));
      chk($sformatf("v%0d_txen", idx), 32'(ft245_txen), 32'(v.etxen));
      chk($sformatf("v%0d_stready", idx), 32'(s_tready), 32'(v.esr));
      chk($sformatf("v%0d_mvalid", idx), 32'(m_tvalid), 32'(v.emv));
      if (v.cm) begin
         chk($sformatf("v%0d_mdata", idx), 32'(m_tdata), 32'(v.emd));
         chk($sformatf("v%0d_mlast", idx), 32'(m_tlast), 32'(v.eml));
         chk($sformatf("v%0d_mkeep", idx), 32'(m_tkeep), 32'(v.emk));
      end
   endtask

   initial begin
      rstn = 1'b0; wakeupn = 1'b1; s_tkeep = 1'b1;
      idle();

      // rstn,frstn,sv,sd, oen,rdn,wrn,siwun,hd,mr, cb,eb,eben, rxfn,txen,srdy,mvld, cm,mdata,mlast,mkeep
      for (int i = 0; i < 5; i++)
         tbl[i] = '{L,H,L,8'h00, H,H,H,H,8'h00,L, L,8'h00,L, H,H,L,L, H,8'h00,L,L};
      tbl[5]  = '{H,H,L,8'h00, H,H,H,H,8'h00,L, L,8'h00,L, H,L,H,L, H,8'h00,L,L};
      tbl[6]  = '{H,H,H,8'h41, H,H,H,H,8'h00,L, L,8'h00,L, H,L,H,L, L,8'h00,L,L};
      tbl[7]  = '{H,H,H,8'h42, H,H,H,H,8'h00,L, L,8'h00,L, L,L,H,L, L,8'h00,L,L};
      tbl[8]  = '{H,H,H,8'h43, H,H,H,H,8'h00,L, H,8'h00,H, L,L,H,L, L,8'h00,L,L};
      tbl[9]  = '{H,H,H,8'h44, H,H,H,H,8'h00,L, L,8'h00,L, L,L,H,L, L,8'h00,L,L};
      tbl[10] = '{H,H,L,8'h00, L,L,H,H,8'h00,L, H,8'h41,H, L,L,H,L, L,8'h00,L,L};
      tbl[11] = '{H,H,L,8'h00, L,L,H,H,8'h00,L, H,8'h42,H, L,L,H,L, L,8'h00,L,L};
      tbl[12] = '{H,H,L,8'h00, L,L,H,H,8'h00,L, H,8'h43,H, L,L,H,L, L,8'h00,L,L};
      tbl[13] = '{H,H,L,8'h00, L,L,H,H,8'h00,L, H,8'h44,H, H,L,H,L, L,8'h00,L,L};
      tbl[14] = '{H,H,L,8'h00, L,L,H,H,8'h00,L, H,8'h00,L, H,L,H,L, L,8'h00,L,L};
      tbl[15] = '{H,H,L,8'h00, H,H,L,H,8'h10,L, L,8'h00,L, H,L,H,H, H,8'h10,L,H};
      tbl[16] = '{H,H,L,8'h00, H,H,L,H,8'h11,L, L,8'h00,L, H,L,H,H, H,8'h10,L,H};
      tbl[17] = '{H,H,L,8'h00, H,H,H,L,8'h00,L, L,8'h00,L, H,L,H,H, H,8'h10,L,H};
      tbl[18] = '{H,H,L,8'h00, H,H,H,H,8'h00,H, L,8'h00,L, H,L,H,H, H,8'h11,H,H};
      tbl[19] = '{H,H,L,8'h00, H,H,L,L,8'h12,H, L,8'h00,L, H,L,H,H, H,8'h12,H,H};
      tbl[20] = '{H,H,L,8'h00, H,H,H,H,8'h00,H, L,8'h00,L, H,L,H,L, L,8'h00,L,L};
      tbl[21] = '{H,H,L,8'h00, H,H,H,L,8'h00,L, L,8'h00,L, H,L,H,L, L,8'h00,L,L};
      tbl[22] = '{H,H,L,8'h00, H,H,L,H,8'h13,L, L,8'h00,L, H,L,H,H, H,8'h13,L,H};
      tbl[23] = '{H,H,L,8'h00, H,H,H,H,8'h00,H, L,8'h00,L, H,L,H,L, L,8'h00,L,L};

      for (int i = 0; i < 24; i++) apply(i, tbl[i]);

      // RX full: 16 pushes with no reads, one refused push, then drain everything
      @(negedge clk);
      idle();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         s_tvalid = 1'b1;
         s_tdata  = 8'h80 + 8'(i);
         @(posedge clk);
         #1;
         if (i == 14) chk("rxfull_rdy_15", 32'(s_tready), 32'd1);
      end
      chk("rxfull_rdy_16", 32'(s_tready), 32'd0);
      @(negedge clk);
      s_tdata = 8'hEE;
      @(posedge clk);
      #1;
      chk("rxfull_rdy_hold", 32'(s_tready), 32'd0);
      @(negedge clk);
      s_tvalid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         oen = 1'b0;
         rdn = 1'b0;
         #1;
         chk($sformatf("rxfull_rd%0d", i), 32'(ft245_data), 32'(8'h80 + 8'(i)));
         @(posedge clk);
         #1;
         if (i == 0) chk("rxfull_rdy_back", 32'(s_tready), 32'd1);
      end
      chk("rxfull_rxfn_empty", 32'(ft245_rxfn), 32'd1);
      @(negedge clk);
      idle();

      // TX full with backpressure, then drain
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         wrn = 1'b0;
         hd  = 8'(i);
         @(posedge clk);
         #1;
         if (i == 14) chk("txfull_txen_15", 32'(ft245_txen), 32'd0);
         if (i == 15) chk("txfull_txen_16", 32'(ft245_txen), 32'd1);
      end
      chk("txfull_txen_20", 32'(ft245_txen), 32'd1);
      @(negedge clk);
      wrn = 1'b1;
      m_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk($sformatf("txdrain_vld%0d", i), 32'(m_tvalid), 32'd1);
         chk($sformatf("txdrain_dat%0d", i), 32'(m_tdata), 32'(i));
         @(posedge clk);
         #1;
         if (i == 0) chk("txdrain_txen_pop1", 32'(ft245_txen), 32'd1);
         if (i == 1) chk("txdrain_txen_pop2", 32'(ft245_txen), 32'd0);
         @(negedge clk);
      end
      #1;
      chk("txdrain_empty", 32'(m_tvalid), 32'd0);
      idle();

      // Flush with 3 RX and 5 TX words queued
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s_tvalid = (i < 3);
         s_tdata  = 8'h60 + 8'(i);
         wrn      = 1'b0;
         hd       = 8'h50 + 8'(i);
         @(posedge clk);
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      wrn = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_pre_rxfn", 32'(ft245_rxfn), 32'd0);
      chk("flush_pre_mvalid", 32'(m_tvalid), 32'd1);
      chk("flush_pre_mdata", 32'(m_tdata), 32'h50);
      @(negedge clk);
      frstn = 1'b0;
      @(posedge clk);
      #1;
      chk("flush_rxfn", 32'(ft245_rxfn), 32'd1);
      chk("flush_mvalid", 32'(m_tvalid), 32'd0);
      chk("flush_txen", 32'(ft245_txen), 32'd0);
      chk("flush_stready", 32'(s_tready), 32'd1);
      chk("flush_mdata_held", 32'(m_tdata), 32'h50);
      @(negedge clk);
      frstn = 1'b1;
      s_tvalid = 1'b1;
      s_tdata = 8'h99;
      @(posedge clk);
      @(negedge clk);
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
      chk("postflush_rxfn", 32'(ft245_rxfn), 32'd0);
      @(negedge clk);
      oen = 1'b0;
      rdn = 1'b0;
      #1;
      chk("postflush_bus", 32'(ft245_data), 32'h99);
      @(posedge clk);
      #1;
      chk("postflush_rxfn_empty", 32'(ft245_rxfn), 32'd1);
      @(negedge clk);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ft245_sync_device.md
# ft245_sync_device

Synthesizable model of the FTDI side of an FT245 synchronous FIFO link. It runs on `ft245_dclk`, presents `ft245_rxfn`/`ft245_txen` flags and a tristate data/byte-enable bus to a host-side FPGA master, and bridges each direction to AXI-Stream through internal FIFOs. It sits opposite `ft245_sync_to_axis` in loopback benches and hardware-free bring-up builds, standing in for the USB chip.

## Interface
- `bus_width`, 1: data bus width in bytes (1, 2 or 4).
- `fifo_depth`, 16: entries per direction FIFO; power of two, at least 4.
- `ft245_dclk`  in  1  sole clock; all logic on its rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `ft245_data`  inout  bus_width*8  driven only while `ft245_oen`=0, else high-Z.
- `ft245_ben`  inout  bus_width  byte enables; driven with `ft245_data`, sampled on writes.
- `ft245_rdn`  in  1  host read strobe, active low.
- `ft245_wrn`  in  1  host write strobe, active low.
- `ft245_oen`  in  1  host output enable, active low.
- `ft245_siwun`  in  1  send-immediate, active low.
- `ft245_rstn`  in  1  chip reset from host, active low; synchronous FIFO flush.
- `ft245_wakeupn`  in  1  ignored.
- `ft245_rxfn`  out  1  0 = RX FIFO holds data for the host.
- `ft245_txen`  out  1  0 = TX FIFO can accept a host write.
- `m_axis_tdata`/`tkeep`/`tlast`/`tvalid`  out  bus_width*8/bus_width/1/1  host-written words.
- `m_axis_tready`  in  1.
- `s_axis_tdata`/`tkeep`  in  bus_width*8/bus_width  words for the host to read.
- `s_axis_tvalid`  in  1; `s_axis_tready` out 1.

## Operation
- RX path (s_axis to host): each entry stores {tkeep, tdata}. Push when `s_axis_tvalid` & `s_axis_tready`. `s_axis_tready` = (rx_count < fifo_depth), gated to 0 while `rstn`=0.
- Bus drive: while `ft245_oen`=0, `ft245_data`/`ft245_ben` = RX head entry. Combinational from head registers. Drives zeros if empty.
- Read transfer: at a rising edge where `rdn`=0, `oen`=0 and `rxfn`=0. Head pops. `rdn` low with `rxfn`=1 has no effect. `rdn` low with `oen`=1 has no effect and no pop.
- TX path (host to m_axis): a write transfer is at a rising edge where `wrn`=0 and `txen`=0. It stores {tlast=~siwun, ben, data}. `wrn` low with `txen`=1 drops the word.
- `ft245_siwun`=0 at an edge with no write sets tlast on the most recently written entry, if that entry is still in the TX FIFO. Otherwise it is ignored.
- `m_axis` presents the TX head. It pops on `tvalid` & `tready`.
- Simultaneous push and pop in either FIFO leaves the count unchanged. Pointers wrap modulo `fifo_depth`. Counts are log2(fifo_depth)+1 bits.
- `ft245_rstn`=0 empties both FIFOs at that edge, like `rstn`, but does not reset the AXIS output registers' data. `m_axis_tvalid` still drops.

## Timing
- Reset (`rstn`=0 at an edge): `rxfn`=1, `txen`=1, bus high-Z, `m_axis_tvalid`=0, `m_axis_tdata`=0, `tkeep`=0, `tlast`=0, `s_axis_tready`=0, counts 0.
- `rxfn` and `txen` are registered from post-edge counts.
  - `rxfn` falls one cycle after the first word is pushed into an empty RX FIFO.
  - `rxfn` rises at the edge that pops the last word, so it is never low with the FIFO empty.
  - `txen` rises at the edge whose write fills the TX FIFO. It falls at the edge after a pop from a full FIFO.
- Read latency: the head is visible on the bus in the same cycle `oen` falls. The host samples it at the next edge with `rdn`=0. The next word appears immediately after a pop.
- `m_axis` latency: a word written at edge N has `m_axis_tvalid`=1 after edge N (registered head, FWFT). It holds stable until accepted.
- With no backpressure, both directions sustain one word per cycle.

## Test plan
- Reset: hold `rstn`=0 for 5 cycles, then release with no traffic. Require `rxfn`=1, `txen`=0 one cycle after release, `s_axis_tready`=1, bus high-Z, and `m_axis_tvalid`=0.
- RX stream: push 0x41..0x44 with `tkeep`=1, then hold `oen`=0 and `rdn`=0 for 4 cycles. Require the host to sample 0x41, 0x42, 0x43, 0x44 in order, `ben`=1, and `rxfn`=1 at the fourth read edge.
- RX full: push 16 words with `rdn` held high. Require `s_axis_tready`=0 after the 16th push. Read one word; require `tready` to return to 1 and no data loss.
- TX full and backpressure: with `m_axis_tready`=0, write 0x00..0x13. Require `txen`=1 after the 16th write and words 16–19 dropped. Then set `tready`=1; require `m_axis` to emit 0x00..0x0F and `txen` to fall one cycle after the first pop.
- Send-immediate: write 0x10 and 0x11, then pulse `siwun`=0 with `wrn`=1. Require `tlast`=0 on 0x10 and `tlast`=1 on 0x11. A write with `siwun`=0 also carries `tlast`=1.
- Flush mid-operation: with 3 RX words and 5 TX words queued, pulse `ft245_rstn`=0 for 1 cycle. Require `rxfn`=1, `m_axis_tvalid`=0, `txen`=0 and `s_axis_tready`=1 on the following cycle.
